jtsdram_led_sched: RTL and testbench

JTSDRAM_LED_SCHED -- requirements
Module: jtsdram_led_sched

---
 rtl/jtsdram_led_sched.sv | 181 ++++++++++++++++++
 tb/tb_jtsdram_led_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/jtsdram_led_sched.sv
// Status LED blink-code scheduler: shows done/busy/bad as 1/2/3 pulses, paced by vertical-blank frame ticks.
// Optional sticky "bad" latch is built when JTSDRAM_LED_STICKY_EN is defined.
module jtsdram_led_sched #(
  parameter int ON_FRAMES  = 4,
  parameter int OFF_FRAMES = 4,
  parameter int GAP_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LVBL,
  input  logic [2:0] req,
  input  logic       clr,
  output logic       led,
  output logic [1:0] src,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [7:0] ON_LOAD  = 8'(ON_FRAMES - 1);
  localparam logic [7:0] OFF_LOAD = 8'(OFF_FRAMES - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_FRAMES - 1);

  logic       lvbl_reg;
  logic       tick;
  logic [4:0] cnt_reg;
  logic [4:0] cnt_next;
  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [7:0] timer_reg;
  logic [7:0] timer_next;
  logic [1:0] pulses_reg;
  logic [1:0] pulses_next;
  logic       led_reg;
  logic       led_next;
  logic [1:0] src_reg;
  logic [1:0] src_next;

  logic [2:0] eff_req;
  logic       sel_any;
  logic [1:0] sel_idx;

  assign tick     = LVBL & ~lvbl_reg;
  assign cnt_next = 5'(cnt_reg + 5'd1);

`ifdef JTSDRAM_LED_STICKY_EN
  logic sticky_reg;

  // clr wins over a simultaneous req[2] so software can always clear the latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else if (clr) begin
      sticky_reg <= 1'b0;
    end else if (req[2]) begin
      sticky_reg <= 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
`endif

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_eff
      if (gi == 2) begin : g_bad
`ifdef JTSDRAM_LED_STICKY_EN
        assign eff_req[gi] = req[gi] | sticky_reg;
`else
        assign eff_req[gi] = req[gi];
`endif
      end else begin : g_plain
        assign eff_req[gi] = req[gi];
      end
    end
  endgenerate

  // Highest set request wins; its index + 1 is the pulse count
  always_comb begin
    sel_any = |eff_req;
    sel_idx = 2'd0;
    if (eff_req[2]) begin
      sel_idx = 2'd2;
    end else if (eff_req[1]) begin
      sel_idx = 2'd1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    pulses_next = pulses_reg;
    led_next    = led_reg;
    src_next    = src_reg;
    if (tick) begin
      case (state_reg)
        S_IDLE: begin
          if (sel_any) begin
            src_next    = sel_idx;
            pulses_next = 2'(sel_idx + 2'd1);
            led_next    = 1'b1;
            timer_next  = ON_LOAD;
            state_next  = S_ON;
          end else begin
            led_next = cnt_next[4];
          end
        end
        S_ON: begin
          if (timer_reg != 8'd0) begin
            timer_next = timer_reg - 8'd1;
          end else begin
            led_next   = 1'b0;
            timer_next = OFF_LOAD;
            state_next = S_OFF;
          end
        end
        S_OFF: begin
          if (timer_reg != 8'd0) begin
            timer_next = timer_reg - 8'd1;
          end else if (pulses_reg > 2'd1) begin
            pulses_next = pulses_reg - 2'd1;
            led_next    = 1'b1;
            timer_next  = ON_LOAD;
            state_next  = S_ON;
          end else begin
            timer_next = GAP_LOAD;
            state_next = S_GAP;
          end
        end
        S_GAP: begin
          if (timer_reg != 8'd0) begin
            timer_next = timer_reg - 8'd1;
          end else if (sel_any) begin
            src_next    = sel_idx;
            pulses_next = 2'(sel_idx + 2'd1);
            led_next    = 1'b1;
            timer_next  = ON_LOAD;
            state_next  = S_ON;
          end else begin
            // Rejoin the heartbeat at the phase the frame counter is about to take
            led_next   = cnt_next[4];
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_reg   <= 1'b0;
      cnt_reg    <= 5'd0;
      state_reg  <= S_IDLE;
      timer_reg  <= 8'd0;
      pulses_reg <= 2'd0;
      led_reg    <= 1'b0;
      src_reg    <= 2'd0;
    end else begin
      lvbl_reg   <= LVBL;
      if (tick) begin
        cnt_reg <= cnt_next;
      end
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      pulses_reg <= pulses_next;
      led_reg    <= led_next;
      src_reg    <= src_next;
    end
  end

  assign led  = led_reg;
  assign src  = src_reg;
  assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_jtsdram_led_sched.sv
// Directed bench for jtsdram_led_sched with ON=2, OFF=2, GAP=4 frame timing.
// Covers JTSDRAM_LED_STICKY_EN behaviour when that macro is defined.
module tb_jtsdram_led_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       LVBL;
  logic [2:0] req;
  logic       clr;
  logic       led;
  logic [1:0] src;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [4:0] tb_cnt;

  // Per-tick expected led, first tick in the MSB
  logic [15:0] pat_done = 16'b1100000011000000;
  logic [15:0] pat_bad  = 16'b1100110011000000;
  logic [11:0] pat_busy = 12'b110011000000;

  always #5 clk = ~clk;

  jtsdram_led_sched #(
    .ON_FRAMES (2),
    .OFF_FRAMES(2),
    .GAP_FRAMES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .LVBL (LVBL),
    .req  (req),
    .clr  (clr),
    .led  (led),
    .src  (src),
    .busy (busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One LVBL rising edge; returns at a negedge after the tick has been registered
  task automatic do_tick();
    @(negedge clk) LVBL = 1'b1;
    @(negedge clk) LVBL = 1'b0;
    tb_cnt = tb_cnt + 5'd1;
    @(negedge clk);
  endtask

  task automatic tick_chk(input string tag, input logic exp_led, input logic [1:0] exp_src,
                          input logic exp_busy);
    do_tick();
    check({tag, "_led"}, 8'(led), 8'(exp_led));
    check({tag, "_src"}, 8'(src), 8'(exp_src));
    check({tag, "_busy"}, 8'(busy), 8'(exp_busy));
  endtask

  initial begin
    rst_n  = 1'b0;
    LVBL   = 1'b0;
    req    = 3'b000;
    clr    = 1'b0;
    tb_cnt = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_led", 8'(led), 8'd0);
    check("rst_src", 8'(src), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    rst_n = 1'b1;

    // Heartbeat: led is cnt[4], toggling every 16 ticks
    for (int k = 1; k <= 64; k++) begin
      logic exp_hb;
      exp_hb = ((k % 32) >= 16);
      do_tick();
      check("hb_led", 8'(led), 8'(exp_hb));
      check("hb_busy", 8'(busy), 8'd0);
    end
    check("hb_src", 8'(src), 8'd0);

    // done held: 1,1,0,0,0,0,0,0 repeating
    req = 3'b001;
    for (int i = 0; i < 16; i++) tick_chk("done", pat_done[15-i], 2'd0, 1'b1);
    req = 3'b000;
    do_tick();
    check("done_idle_busy", 8'(busy), 8'd0);
    check("done_idle_led", 8'(led), 8'(tb_cnt[4]));

    // busy+bad held: bad wins, three pulses, then restarts straight from GAP
    req = 3'b110;
    for (int i = 0; i < 16; i++) tick_chk("bad", pat_bad[15-i], 2'd2, 1'b1);
    tick_chk("bad_restart", 1'b1, 2'd2, 1'b1);
    // Request change mid-code must not disturb the running bad code
    req = 3'b001;
    for (int i = 1; i < 16; i++) tick_chk("bad_hold", pat_bad[15-i], 2'd2, 1'b1);
    tick_chk("resel", 1'b1, 2'd0, 1'b1);
    req = 3'b000;
    for (int i = 1; i < 8; i++) tick_chk("done_tail", pat_done[15-i], 2'd0, 1'b1);
    do_tick();
    check("tail_idle_busy", 8'(busy), 8'd0);
    check("tail_idle_led", 8'(led), 8'(tb_cnt[4]));

    // busy request for a single tick still completes its two-pulse code
    req = 3'b010;
    tick_chk("busy_start", 1'b1, 2'd1, 1'b1);
    req = 3'b000;
    for (int i = 1; i < 12; i++) tick_chk("busy_code", pat_busy[11-i], 2'd1, 1'b1);
    do_tick();
    check("busy_idle_busy", 8'(busy), 8'd0);
    check("busy_idle_led", 8'(led), 8'(tb_cnt[4]));
    check("busy_idle_src", 8'(src), 8'd1);

`ifndef JTSDRAM_LED_STICKY_EN
    // Without the latch a non-tick req[2] pulse is forgotten
    @(negedge clk) req = 3'b100;
    @(negedge clk) req = 3'b000;
    clr = 1'b1;
    do_tick();
    clr = 1'b0;
    check("nolatch_busy", 8'(busy), 8'd0);
`endif

    // Asynchronous reset in the middle of an ON phase
    req = 3'b100;
    tick_chk("rst_on1", 1'b1, 2'd2, 1'b1);
    tick_chk("rst_on2", 1'b1, 2'd2, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("arst_led", 8'(led), 8'd0);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_src", 8'(src), 8'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    tb_cnt = 5'd0;
    tick_chk("rst_restart", 1'b1, 2'd2, 1'b1);

`ifdef JTSDRAM_LED_STICKY_EN
    @(negedge clk) rst_n = 1'b0;
    req = 3'b000;
    @(negedge clk) rst_n = 1'b1;
    tb_cnt = 5'd0;
    // One-cycle bad pulse outside any tick sets the latch
    @(negedge clk) req = 3'b100;
    @(negedge clk) req = 3'b000;
    for (int i = 0; i < 16; i++) tick_chk("sticky", pat_bad[15-i], 2'd2, 1'b1);
    tick_chk("sticky_rep", 1'b1, 2'd2, 1'b1);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    for (int i = 1; i < 16; i++) tick_chk("sticky_fin", pat_bad[15-i], 2'd2, 1'b1);
    do_tick();
    check("sticky_idle_busy", 8'(busy), 8'd0);
    check("sticky_idle_led", 8'(led), 8'(tb_cnt[4]));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
